seq_ctrl: RTL and testbench
===========================

Name: seq_ctrl

Overview:
Multi-cycle sequencer for the Y86-64 sequential core. Owns the architectural PC and the status register. Steps each instruction through fetch, decode, execute, memory, writeback and PC-update by issuing one-hot stage enables to the existing stage blocks. Handshakes with data memory, and halts on halt/error conditions reported by fetch or memory.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 16, max MEMORY-state cycles without dmem_ack before ADR fault (must be >=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  1 = keep issuing instructions; 0 = park in IDLE at next instruction boundary
icode  in  4  from fetch, valid during FETCH
imem_err  in  1  fetch mem_err, valid during FETCH
instruct_err  in  1  fetch invalid-instruction flag, valid during FETCH
valC  in  64  from fetch, valid during FETCH
valP  in  64  from fetch, valid during FETCH
cnd  in  1  condition flag from execute, valid during EXECUTE
valM  in  64  data-memory read value, valid with dmem_ack
dmem_ack  in  1  data-memory completion
dmem_err  in  1  data-memory address error, qualified by dmem_ack
PC  out  64  architectural PC, drives fetch
fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  one-hot stage enables
dmem_req  out  1  data-memory request
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
halted  out  1  high in HALT state
retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate): state=IDLE, PC=RESET_PC, stat=AOK, retired=0, timeout count=0.
- Reset state of outputs: all enables=0, dmem_req=0, halted=0.
- Reset mid-instruction aborts it with no PC or counter update.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH (fetch_en=1, one cycle): latch icode_q, valC_q, valP_q, then branch by priority:
  - imem_err -> stat=ADR, HALT
  - else instruct_err -> stat=INS, HALT
  - else icode==0 -> stat=HLT, HALT
  - else -> DECODE
- DECODE (decode_en=1) -> EXECUTE.
- EXECUTE (exec_en=1): latch cnd_q. If icode_q is in {4,5,8,9,A,B} -> MEMORY, else -> WRITEBACK.
- MEMORY (mem_en=1, dmem_req=1): dmem_req is held until dmem_ack; the timeout counter increments each cycle without ack.
  - ack & dmem_err -> stat=ADR, HALT.
  - ack & !dmem_err -> latch valM_q, go to WRITEBACK.
  - No ack on the MEM_TIMEOUT-th cycle -> stat=ADR, HALT.
  - Ack on that same cycle wins over the timeout.
  - dmem_req deasserts in the cycle after ack/timeout; the counter clears on MEMORY exit.
- WRITEBACK (wb_en=1) -> PCUPD.
- PCUPD:
  - PC <= new_pc: icode_q=8 -> valC_q; icode_q=7 & cnd_q -> valC_q; icode_q=9 -> valM_q; else valP_q.
  - retired += 1.
  - Next state: run ? FETCH : IDLE.
- HALT: halted=1; absorbing until reset. PC is not updated, so it stays at the faulting/halt instruction. retired is not incremented.
- Latency: non-memory instruction = 5 cycles FETCH->PCUPD inclusive. Memory instruction = 6 + (cycles waiting for ack).
- run deasserted mid-instruction has no effect until PCUPD completes.
- No enable is asserted outside its state. Exactly one enable is high in FETCH..WRITEBACK; none in IDLE, PCUPD or HALT.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (HALT=0 ... POPQ=B)
  - stat codes (AOK/HLT/ADR/INS)
  - state encoding
  - helper function uses_mem(icode)
- One combinational sub-module, seq_pc_sel: inputs icode_q, cnd_q, valC_q, valP_q, valM_q; output new_pc. It is reused later by the pipelined PC predictor.

Test Plan:
- Reset with RESET_PC=34, run=1, icode=6 (OPq), valP=36 -> enables pulse F,D,E,W over 4 cycles, then PCUPD. PC=36 and retired=1 after 5 cycles; dmem_req never asserted.
- jXX: icode=7, valC=0x300, valP=0x5A. With cnd=1 -> PC=0x300; repeat with cnd=0 -> PC=0x5A.
- ret: icode=9, dmem_ack after 3 wait cycles with valM=0x1234 -> dmem_req high 4 cycles; PC=0x1234; 9-cycle instruction.
- Faults:
  - imem_err=1 in FETCH -> stat=3, halted=1, PC unchanged, retired unchanged.
  - icode=0 -> stat=2.
  - instruct_err=1 -> stat=4.
  - run held 1 afterwards -> stays HALT.
- rmmovq with no ack, MEM_TIMEOUT=16 -> dmem_req high exactly 16 cycles, then stat=3, HALT. Ack with dmem_err=1 on cycle 16 -> also ADR. Ack with dmem_err=0 on cycle 16 -> WRITEBACK.
- Assert reset mid-MEMORY -> dmem_req=0, PC=RESET_PC, stat=1 immediately (same cycle, before next clk edge). run=0 during EXECUTE -> instruction retires, then IDLE.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants, status codes, sequencer state encoding and helpers.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] ST_AOK = 3'd1;
    localparam logic [2:0] ST_HLT = 3'd2;
    localparam logic [2:0] ST_ADR = 3'd3;
    localparam logic [2:0] ST_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
    } state_t;

    function automatic logic uses_mem(input logic [3:0] ic);
        return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
    endfunction

endpackage

// File: rtl/seq_pc_sel.sv
// seq_pc_sel: next-PC selection for the sequential core.
//   in : icode_q, cnd_q, valC_q, valP_q, valM_q (latched instruction fields)
//   out: new_pc (call/taken jump -> valC, ret -> valM, otherwise valP)
module seq_pc_sel
    import y86_pkg::*;
(
    input  logic [3:0]  icode_q,
    input  logic        cnd_q,
    input  logic [63:0] valC_q,
    input  logic [63:0] valP_q,
    input  logic [63:0] valM_q,
    output logic [63:0] new_pc
);

    always_comb
        new_pc = (icode_q == I_CALL || (icode_q == I_JXX && cnd_q)) ? valC_q :
                 (icode_q == I_RET) ? valM_q : valP_q;

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle Y86-64 sequencer owning PC, status and retired count.
//   in : clk, reset (async high), run, fetch fields (icode, imem_err, instruct_err,
//        valC, valP), cnd from execute, data-memory response (valM, dmem_ack, dmem_err)
//   out: PC, one-hot stage enables, dmem_req, stat, halted, retired
module seq_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          CNT_W       = 32,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       icode,
    input  logic             imem_err,
    input  logic             instruct_err,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic             cnd,
    input  logic [63:0]      valM,
    input  logic             dmem_ack,
    input  logic             dmem_err,
    output logic [63:0]      PC,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             dmem_req,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       stat_q, stat_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [63:0]      pc_q, valC_q, valP_q, valM_q, new_pc;
    logic [3:0]       icode_q;
    logic             cnd_q;
    logic [CNT_W-1:0] retired_q;

    seq_pc_sel u_pc_sel (
        .icode_q(icode_q),
        .cnd_q  (cnd_q),
        .valC_q (valC_q),
        .valP_q (valP_q),
        .valM_q (valM_q),
        .new_pc (new_pc)
    );

    // tmo_d defaults to zero so the wait counter clears whenever MEMORY is left.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        tmo_d   = '0;
        case (state_q)
            S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                state_d = (imem_err || instruct_err || icode == I_HALT) ? S_HALT : S_DECODE;
                stat_d  = imem_err ? ST_ADR : instruct_err ? ST_INS :
                          (icode == I_HALT) ? ST_HLT : stat_q;
            end
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = uses_mem(icode_q) ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                // An ack on the final allowed cycle takes priority over the timeout.
                if (dmem_ack) begin
                    state_d = dmem_err ? S_HALT : S_WRITEBACK;
                    stat_d  = dmem_err ? ST_ADR : stat_q;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_HALT;
                    stat_d  = ST_ADR;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD:     state_d = run ? S_FETCH : S_IDLE;
            default:     state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            stat_q    <= ST_AOK;
            tmo_q     <= '0;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            icode_q   <= I_HALT;
            cnd_q     <= 1'b0;
            valC_q    <= '0;
            valP_q    <= '0;
            valM_q    <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            tmo_q   <= tmo_d;
            if (state_q == S_FETCH) begin
                icode_q <= icode;
                valC_q  <= valC;
                valP_q  <= valP;
            end
            if (state_q == S_EXECUTE)
                cnd_q <= cnd;
            if (state_q == S_MEMORY && dmem_ack && !dmem_err)
                valM_q <= valM;
            if (state_q == S_PCUPD) begin
                pc_q      <= new_pc;
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    assign fetch_en  = state_q == S_FETCH;
    assign decode_en = state_q == S_DECODE;
    assign exec_en   = state_q == S_EXECUTE;
    assign mem_en    = state_q == S_MEMORY;
    assign wb_en     = state_q == S_WRITEBACK;
    assign dmem_req  = state_q == S_MEMORY;
    assign halted    = state_q == S_HALT;
    assign PC        = pc_q;
    assign stat      = stat_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed self-checking bench for seq_ctrl.
module tb_seq_ctrl;

    logic        clk, reset, run, imem_err, instruct_err, cnd, dmem_ack, dmem_err;
    logic [3:0]  icode;
    logic [63:0] valC, valP, valM, PC;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, dmem_req, halted;
    logic [2:0]  stat;
    logic [31:0] retired;
    logic [4:0]  en;

    int checks = 0;
    int errors = 0;
    int ack_delay = -1;
    logic ack_err = 0;
    int mcyc = 0;
    int cyc, reqs;

    seq_ctrl #(.RESET_PC(64'd34), .CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .run(run), .icode(icode), .imem_err(imem_err),
        .instruct_err(instruct_err), .valC(valC), .valP(valP), .cnd(cnd), .valM(valM),
        .dmem_ack(dmem_ack), .dmem_err(dmem_err), .PC(PC), .fetch_en(fetch_en),
        .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en),
        .dmem_req(dmem_req), .stat(stat), .halted(halted), .retired(retired)
    );

    assign en = {fetch_en, decode_en, exec_en, mem_en, wb_en};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Data-memory responder: acks on wait cycle ack_delay+1 of a request (never if -1).
    initial begin
        dmem_ack = 0;
        dmem_err = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dmem_req) begin
                mcyc++;
                dmem_ack = (mcyc == ack_delay + 1);
                dmem_err = dmem_ack && ack_err;
            end else begin
                mcyc = 0;
                dmem_ack = 0;
                dmem_err = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        run = 0;
        reset = 1;
        #1;
        tick;
        reset = 0;
    endtask

    task automatic setup(input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p,
                         input logic ie, input logic xe, input logic cd);
        icode = ic;
        valC = c;
        valP = p;
        imem_err = ie;
        instruct_err = xe;
        cnd = cd;
    endtask

    // Starts one instruction from IDLE, counts cycles FETCH..PCUPD (or ..HALT) and request cycles.
    task automatic exec_insn(output int c, output int r);
        logic done;
        done = 0;
        c = 0;
        r = 0;
        run = 1;
        tick;
        for (int i = 0; i < 64 && !done; i++) begin
            c++;
            if (dmem_req) r++;
            if (en == 5'b0) done = 1;
            else tick;
        end
        chk("insn_bound", {63'd0, done}, 64'd1);
        run = 0;
        tick;
    endtask

    initial begin
        reset = 0;
        run = 0;
        valM = 64'h1234;
        setup(4'h6, 64'h0, 64'd36, 0, 0, 0);
        #2;
        reset = 1;
        #1;
        chk("rst_pc", PC, 64'd34);
        chk("rst_stat", {61'd0, stat}, 64'd1);
        chk("rst_retired", {32'd0, retired}, 64'd0);
        chk("rst_en", {59'd0, en}, 64'd0);
        chk("rst_req_halt", {62'd0, dmem_req, halted}, 64'd0);
        tick;
        reset = 0;

        // OPq: F, D, E, W enables then PCUPD
        run = 1;
        tick; chk("opq_f", {59'd0, en}, 64'b10000); reqs = int'(dmem_req);
        tick; chk("opq_d", {59'd0, en}, 64'b01000); reqs += int'(dmem_req);
        tick; chk("opq_e", {59'd0, en}, 64'b00100); reqs += int'(dmem_req);
        tick; chk("opq_w", {59'd0, en}, 64'b00001); reqs += int'(dmem_req);
        tick; chk("opq_pcupd_en", {59'd0, en, halted}, 64'd0);
        chk("opq_pc_before", PC, 64'd34);
        run = 0;
        tick;
        chk("opq_pc", PC, 64'd36);
        chk("opq_retired", {32'd0, retired}, 64'd1);
        chk("opq_noreq", 64'(reqs), 64'd0);

        // jXX taken / not taken
        setup(4'h7, 64'h300, 64'h5A, 0, 0, 1);
        exec_insn(cyc, reqs);
        chk("jxx_t_cyc", 64'(cyc), 64'd5);
        chk("jxx_t_pc", PC, 64'h300);
        setup(4'h7, 64'h300, 64'h5A, 0, 0, 0);
        exec_insn(cyc, reqs);
        chk("jxx_nt_pc", PC, 64'h5A);
        chk("jxx_retired", {32'd0, retired}, 64'd3);

        // ret with 3 wait cycles
        ack_delay = 3;
        ack_err = 0;
        setup(4'h9, 64'h0, 64'h99, 0, 0, 0);
        exec_insn(cyc, reqs);
        chk("ret_cyc", 64'(cyc), 64'd9);
        chk("ret_reqs", 64'(reqs), 64'd4);
        chk("ret_pc", PC, 64'h1234);
        chk("ret_retired", {32'd0, retired}, 64'd4);

        // fetch fault: imem_err -> ADR, PC/retired frozen, absorbing with run held
        setup(4'h6, 64'h0, 64'h77, 1, 1, 0);
        exec_insn(cyc, reqs);
        chk("imem_stat", {61'd0, stat}, 64'd3);
        chk("imem_halted", {63'd0, halted}, 64'd1);
        chk("imem_pc", PC, 64'h1234);
        chk("imem_retired", {32'd0, retired}, 64'd4);
        run = 1;
        setup(4'h6, 64'h0, 64'h77, 0, 0, 0);
        tick; tick; tick;
        chk("halt_stays", {59'd0, en, halted}, 64'd1);
        chk("halt_stat", {61'd0, stat}, 64'd3);
        chk("halt_pc", PC, 64'h1234);

        do_reset;
        setup(4'h0, 64'h0, 64'h77, 0, 0, 0);
        exec_insn(cyc, reqs);
        chk("hlt_stat", {61'd0, stat}, 64'd2);
        chk("hlt_pc", PC, 64'd34);

        do_reset;
        setup(4'h0, 64'h0, 64'h77, 0, 1, 0);
        exec_insn(cyc, reqs);
        chk("ins_stat", {61'd0, stat}, 64'd4);
        chk("ins_retired", {32'd0, retired}, 64'd0);

        // rmmovq: timeout, ack+err on last cycle, ack ok on last cycle
        do_reset;
        ack_delay = -1;
        setup(4'h4, 64'h0, 64'h80, 0, 0, 0);
        exec_insn(cyc, reqs);
        chk("tmo_reqs", 64'(reqs), 64'd16);
        chk("tmo_stat", {61'd0, stat}, 64'd3);
        chk("tmo_halted", {63'd0, halted}, 64'd1);

        do_reset;
        ack_delay = 15;
        ack_err = 1;
        exec_insn(cyc, reqs);
        chk("ackerr_reqs", 64'(reqs), 64'd16);
        chk("ackerr_stat", {61'd0, stat}, 64'd3);

        do_reset;
        ack_err = 0;
        exec_insn(cyc, reqs);
        chk("acklast_cyc", 64'(cyc), 64'd21);
        chk("acklast_stat", {61'd0, stat}, 64'd1);
        chk("acklast_pc", PC, 64'h80);
        chk("acklast_retired", {32'd0, retired}, 64'd1);

        // reset mid-MEMORY is immediate
        ack_delay = -1;
        setup(4'h5, 64'h0, 64'h90, 0, 0, 0);
        run = 1;
        tick; tick; tick; tick;
        chk("mid_req", {63'd0, dmem_req}, 64'd1);
        reset = 1;
        #1;
        chk("mid_rst_req", {63'd0, dmem_req}, 64'd0);
        chk("mid_rst_pc", PC, 64'd34);
        chk("mid_rst_stat", {61'd0, stat}, 64'd1);
        chk("mid_rst_retired", {32'd0, retired}, 64'd0);
        run = 0;
        tick;
        reset = 0;

        // run dropped during EXECUTE: instruction retires, then IDLE
        setup(4'h6, 64'h0, 64'h40, 0, 0, 0);
        run = 1;
        tick; tick; tick;
        chk("rd_exec", {59'd0, en}, 64'b00100);
        run = 0;
        tick; tick; tick;
        chk("rd_pc", PC, 64'h40);
        chk("rd_retired", {32'd0, retired}, 64'd1);
        tick;
        chk("rd_idle", {59'd0, en, halted}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
